// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM responder model.
// Optional statistics counters are enabled with the SDRAM_STATS_EN macro.
package sdram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } sdram_state_e;

  localparam logic SDRAM_WR = 1'b1;
  localparam logic SDRAM_RD = 1'b0;
  localparam int   SDRAM_LATENCY_DEFAULT = 4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sdram_mem_array.sv
// Byte array with one synchronous write port and one registered read port.
// Stores each byte XOR its address fill pattern, so an all-zero array reads as mem[a] = a[DW-1:0].
module sdram_mem_array
  import sdram_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Zero difference everywhere == the time-zero fill; reset never touches this array.
  logic [DATA_WIDTH-1:0] diff_mem [DEPTH] = '{default: '0};

  function automatic logic [DATA_WIDTH-1:0] fill(input logic [ADDR_WIDTH-1:0] a);
    return DATA_WIDTH'(a);
  endfunction

  always_ff @(posedge clk) begin
    if (we) diff_mem[waddr] <= wdata ^ fill(waddr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= diff_mem[raddr] ^ fill(raddr);
  end

endmodule

// File: rtl/sdram_model_ctrl.sv
// Cycle-accurate SDRAM responder: latches one strobed byte request, waits LATENCY cycles, then commits or returns data.
// Define SDRAM_STATS_EN to add saturating read/write completion counters.
module sdram_model_ctrl
  import sdram_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LATENCY    = SDRAM_LATENCY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Address_sdram,
  input  logic                  wr_rd_sdram,
  input  logic                  mstrb_sdram,
  input  logic [DATA_WIDTH-1:0] DIn_sdram,
  output logic [DATA_WIDTH-1:0] DOut_sdram,
  output logic                  dvalid_sdram,
  output logic                  done_sdram,
  output logic                  busy_sdram,
  output logic                  overrun_sdram,
`ifdef SDRAM_STATS_EN
  output logic [15:0]           rd_count_sdram,
  output logic [15:0]           wr_count_sdram,
`endif
  output sdram_state_e          dbg_state
);

  // Handshake: a request is accepted on any rising edge with mstrb_sdram=1 while in IDLE;
  // a strobe in ACCESS or DONE is dropped and flagged; done/dvalid are single-cycle pulses.

  sdram_state_e          state;
  logic [7:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  access_end;

  assign access_end = (state == ACCESS) && (cnt == 8'd0);
  assign dbg_state  = state;

  sdram_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst),
    .we    (access_end && (wr_q == SDRAM_WR)),
    .waddr (addr_q),
    .wdata (din_q),
    .re    (access_end && (wr_q == SDRAM_RD)),
    .raddr (addr_q),
    .rdata (DOut_sdram)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      addr_q        <= '0;
      wr_q          <= 1'b0;
      din_q         <= '0;
      dvalid_sdram  <= 1'b0;
      done_sdram    <= 1'b0;
      busy_sdram    <= 1'b0;
      overrun_sdram <= 1'b0;
    end else begin
      dvalid_sdram <= 1'b0;
      done_sdram   <= 1'b0;
      if (mstrb_sdram && (state != IDLE)) overrun_sdram <= 1'b1;
      case (state)
        IDLE: begin
          if (mstrb_sdram) begin
            addr_q     <= Address_sdram;
            wr_q       <= wr_rd_sdram;
            din_q      <= DIn_sdram;
            cnt        <= 8'(LATENCY - 1);
            busy_sdram <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 8'd0) begin
            done_sdram   <= 1'b1;
            dvalid_sdram <= (wr_q == SDRAM_RD);
            state        <= DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          busy_sdram <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy_sdram <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef SDRAM_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count_sdram <= 16'd0;
      wr_count_sdram <= 16'd0;
    end else if (state == DONE) begin
      if (wr_q == SDRAM_WR) wr_count_sdram <= sat_inc16(wr_count_sdram);
      else                  rd_count_sdram <= sat_inc16(rd_count_sdram);
    end
  end
`endif

endmodule

// File: tb/tb_sdram_model_ctrl.sv
// Directed self-checking bench for sdram_model_ctrl with a byte-array reference model and read-data scoreboard.
module tb_sdram_model_ctrl;
  import sdram_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] Address_sdram = '0;
  logic          wr_rd_sdram = 1'b0;
  logic          mstrb_sdram = 1'b0;
  logic [DW-1:0] DIn_sdram = '0;
  logic [DW-1:0] DOut_sdram;
  logic          dvalid_sdram;
  logic          done_sdram;
  logic          busy_sdram;
  logic          overrun_sdram;
`ifdef SDRAM_STATS_EN
  logic [15:0]   rd_count_sdram;
  logic [15:0]   wr_count_sdram;
`endif
  sdram_state_e  dbg_state;

  sdram_model_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .Address_sdram (Address_sdram),
    .wr_rd_sdram   (wr_rd_sdram),
    .mstrb_sdram   (mstrb_sdram),
    .DIn_sdram     (DIn_sdram),
    .DOut_sdram    (DOut_sdram),
    .dvalid_sdram  (dvalid_sdram),
    .done_sdram    (done_sdram),
    .busy_sdram    (busy_sdram),
    .overrun_sdram (overrun_sdram),
`ifdef SDRAM_STATS_EN
    .rd_count_sdram(rd_count_sdram),
    .wr_count_sdram(wr_count_sdram),
`endif
    .dbg_state     (dbg_state)
  );

  // Clock/reset block
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model and scoreboard
  logic [DW-1:0] tb_mem [65536];
  logic [DW-1:0] exp_q [$];
  int            n_total = 0;
  int            n_pass  = 0;
  int            n_rd    = 0;
  int            n_wr    = 0;
  logic [AW-1:0] cur_addr;
  logic          cur_wr;
  logic [DW-1:0] cur_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Driver: called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic issue_req(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d);
    cur_addr      = a;
    cur_wr        = wr;
    cur_din       = d;
    Address_sdram = a;
    wr_rd_sdram   = wr;
    DIn_sdram     = d;
    mstrb_sdram   = 1'b1;
    if (wr == SDRAM_RD) exp_q.push_back(tb_mem[a]);
    @(posedge clk);
    @(negedge clk);
    mstrb_sdram = 1'b0;
  endtask

  // Monitor: samples each falling edge until busy drops (bounded), scoring the completion.
  task automatic wait_req(output int lat, output int busy_n);
    logic [DW-1:0] e;
    lat    = 0;
    busy_n = 0;
    for (int i = 1; i <= LAT + 20; i++) begin
      if (busy_sdram) busy_n++;
      if (done_sdram) begin
        lat = i;
        chk("dvalid_on_read", 32'(dvalid_sdram), 32'(cur_wr == SDRAM_RD));
        if (cur_wr == SDRAM_RD) begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
          chk("read_data", 32'(DOut_sdram), 32'(e));
          n_rd++;
        end else begin
          tb_mem[cur_addr] = cur_din;
          n_wr++;
        end
      end
      if (!busy_sdram) break;
      @(negedge clk);
    end
    chk("req_completed", 32'(lat != 0), 32'd1);
    chk("pulses_cleared", 32'(done_sdram | dvalid_sdram), 32'd0);
  endtask

  task automatic xfer(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d);
    int l, b;
    issue_req(a, wr, d);
    wait_req(l, b);
  endtask

  initial begin
    int lat, bn;
    int unsigned t0;
    for (int i = 0; i < 65536; i++) tb_mem[i] = 8'(i);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(DOut_sdram), 32'd0);
    chk("rst_busy", 32'(busy_sdram), 32'd0);
    chk("rst_done", 32'(done_sdram | dvalid_sdram), 32'd0);
    chk("rst_overrun", 32'(overrun_sdram), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    @(negedge clk);

    // Single read: dvalid on the 5th sampled cycle, busy spans edges k..k+LAT+1
    issue_req(16'h1234, SDRAM_RD, 8'h00);
    wait_req(lat, bn);
    chk("read_latency", 32'(lat), 32'(LAT + 1));
    chk("busy_cycles", 32'(bn), 32'(LAT + 1));
    @(negedge clk);
    chk("dout_hold_idle", 32'(DOut_sdram), 32'h34);

    // Write then read back, neighbour untouched
    xfer(16'h00E0, SDRAM_WR, 8'hA5);
    chk("dout_hold_after_write", 32'(DOut_sdram), 32'h34);
    xfer(16'h00E0, SDRAM_RD, 8'h00);
    xfer(16'h00E1, SDRAM_RD, 8'h00);

    // Line fill: 32 back-to-back reads
    t0 = cyc;
    for (int i = 0; i < 32; i++) xfer(16'(32'h2000 + i), SDRAM_RD, 8'h00);
    chk("line_fill_cycles", cyc - t0, 32'd192);
    chk("line_fill_no_overrun", 32'(overrun_sdram), 32'd0);

    // Address extremes and random traffic
    xfer(16'hFFFF, SDRAM_WR, 8'hC3);
    xfer(16'hFFFF, SDRAM_RD, 8'h00);
    xfer(16'h0000, SDRAM_RD, 8'h00);
    for (int i = 0; i < 12; i++) begin
      xfer(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end
    xfer(16'h00E0, SDRAM_RD, 8'h00);

    // Overrun: second strobe one cycle after acceptance is dropped
    issue_req(16'h3055, SDRAM_RD, 8'h00);
    Address_sdram = 16'h3055;
    wr_rd_sdram   = SDRAM_WR;
    DIn_sdram     = 8'h77;
    mstrb_sdram   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mstrb_sdram = 1'b0;
    chk("overrun_set", 32'(overrun_sdram), 32'd1);
    wait_req(lat, bn);
    xfer(16'h3055, SDRAM_RD, 8'h00);
    chk("overrun_sticky", 32'(overrun_sdram), 32'd1);

    // Reset during ACCESS of a write
    issue_req(16'h0010, SDRAM_WR, 8'h5A);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_sdram), 32'd0);
    chk("midrst_dout", 32'(DOut_sdram), 32'd0);
    chk("midrst_pulses", 32'(done_sdram | dvalid_sdram), 32'd0);
    chk("midrst_overrun", 32'(overrun_sdram), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(IDLE));
    n_rd = 0;
    n_wr = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xfer(16'h0010, SDRAM_RD, 8'h00);

    // Mixed traffic with one dropped strobe
    xfer(16'h4000, SDRAM_WR, 8'h11);
    issue_req(16'h4001, SDRAM_WR, 8'h22);
    wr_rd_sdram = SDRAM_RD;
    mstrb_sdram = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mstrb_sdram = 1'b0;
    wait_req(lat, bn);
    xfer(16'h4002, SDRAM_WR, 8'h33);
    xfer(16'h4001, SDRAM_RD, 8'h00);
    chk("overrun_after_reset", 32'(overrun_sdram), 32'd1);
`ifdef SDRAM_STATS_EN
    chk("rd_count", 32'(rd_count_sdram), 32'(n_rd));
    chk("wr_count", 32'(wr_count_sdram), 32'(n_wr));
`endif
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
